// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to include the even-parity bit between data and stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_start,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_tx
);

  localparam int CNT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int BIT_W   = $clog2(CNT_MAX + 1);
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || DATA_W < 5 || DATA_W > 9 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
      $error("uart_tx: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [BAUD_W-1:0]   r_baud;
  logic [BIT_W-1:0]    r_bit;
  logic                r_tx;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif
  logic                w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  // o_tx is registered one bit ahead: each transition loads the level of the bit being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_baud <= (w_bit_end || r_state == S_IDLE || r_state == S_DONE) ? '0 : r_baud + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shift  <= i_data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^i_data;
`endif
            r_state  <= S_START;
            r_tx     <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_bit    <= '0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_bit   <= '0;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit == DATA_LAST) begin
              r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_bit   <= '0;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit == STOP_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_bit   <= '0;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_bit   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx    = r_tx;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit engine, the transmit-side counterpart of the team's UART receiver. It serializes one parallel word per handshake into an asynchronous frame: start bit, data LSB first, optional parity, then stop bit(s). Baud timing comes from an internal clock-divider counter, so no external baud-enable is needed. The block sits between the host/register side (`i_data`/`i_start`) and the serial pad (`o_tx`).

Parameters:
- `CLKS_PER_BIT`, 16: clk cycles per serial bit. Legal range ≥2.
- `DATA_W`, 8: data bits per frame. Legal range 5..9.
- `STOP_BITS`, 1: number of stop bits. Legal values are 1 or 2.

Ports:
- `clk`, input, 1: single system clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `i_data`, input, `DATA_W`: word to transmit. Sampled only on acceptance.
- `i_start`, input, 1: transmit request. Accepted when `i_start` and `o_ready` are both high at a rising edge.
- `o_ready`, output, 1: high only in IDLE. Asserted means the block can accept a word.
- `o_busy`, output, 1: high from the cycle after acceptance through the DONE cycle.
- `o_done`, output, 1: one-cycle pulse after the final stop bit completes.
- `o_tx`, output, 1: serial line. Idles high and is driven from a register, with no combinational path to the pad.

Behaviour:
- Reset values: state=IDLE, `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_done`=0. The shift register, baud counter and bit counter are all cleared.
- Reset mid-frame takes effect at the next edge. The frame is abandoned, `o_tx` returns to 1, and no `o_done` is generated.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: `o_tx`=1. On acceptance, the block latches `i_data` into the shift register and moves to START.
  - START: `o_tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: `o_tx` = shift register bit 0, each bit held `CLKS_PER_BIT` cycles. The register shifts right at each bit boundary. After `DATA_W` bits the FSM goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: `o_tx` = parity bit for `CLKS_PER_BIT` cycles, then STOP.
  - STOP: `o_tx`=1 for `STOP_BITS`*`CLKS_PER_BIT` cycles, then DONE.
  - DONE: `o_tx`=1, `o_done`=1, `o_ready`=0, for exactly one cycle, then IDLE.
- Latency: if acceptance is at edge k, `o_tx` falls in the cycle after edge k.
  - Frame length is N = 1 + `DATA_W` + P + `STOP_BITS` bits, where P is 1 with parity enabled and 0 without.
  - `o_done` is high during the cycle following edge k + N*`CLKS_PER_BIT`.
- Baud counter: counts 0..`CLKS_PER_BIT`-1. It wraps to 0 at each bit boundary and is held at 0 in IDLE and DONE.
- Bit counter: width is $clog2 of max(`DATA_W`, `STOP_BITS`)+1. It is reused for data and stop bits and is cleared on each state entry.
- Handshake rules:
  - `i_start` is ignored while not in IDLE. It does not queue.
  - `i_data` changes after acceptance do not affect the frame in flight.
  - `i_start` held high continuously gives back-to-back frames with exactly 2 idle-high cycles between frames (DONE + IDLE).
- `o_ready` = (state==IDLE). `o_busy` = (state != IDLE).
- Illegal parameter values produce an elaboration-time error via a generate-time check.

Optional Feature:
- Macro: `UART_TX_PARITY_EN`.
- When defined: the PARITY state exists and P=1. The parity bit is even parity, i.e. the XOR of the latched `DATA_W` bits, computed at acceptance and stored in a flop.
- When undefined: the PARITY state, its flop and the XOR logic are not compiled. DATA goes directly to STOP, and P=0.

Test Plan:
- Basic frame, no parity: `CLKS_PER_BIT`=4, `DATA_W`=8, `STOP_BITS`=1, send 0x55.
  - `o_tx` = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
  - `o_done` pulses 40 cycles after acceptance.
  - `o_ready` returns high on the following cycle.
- Parity on (`UART_TX_PARITY_EN`), send 0xA7 (LSB-first bits 1,1,1,0,0,1,0,1; five ones).
  - Parity bit = 1.
  - Frame is 11 bits; `o_done` at 44 cycles.
- `STOP_BITS`=2, no parity, send 0x00.
  - `o_tx` is low for 36 cycles, then high for 8 cycles.
  - `o_done` at 44 cycles.
- Busy-ignore: during the DATA state of a 0x3C frame, pulse `i_start` with `i_data`=0xFF.
  - The serialized 0x3C frame is unchanged.
  - Exactly one `o_done` occurs.
  - No second frame starts.
- Back-to-back: hold `i_start`=1 with 0x81 then 0x7E.
  - Two correct frames are sent.
  - Exactly 2 high cycles separate the stop bit of frame 1 from the start bit of frame 2.
- Reset mid-frame: assert `rst` for one cycle at bit 3 of DATA.
  - Next cycle: `o_tx`=1, `o_ready`=1, `o_busy`=0.
  - No `o_done` is produced.
  - A subsequent send of 0x12 is correct.
